// File: rtl/coder_prio.sv
// Registered priority / one-hot encoder with valid-ready handshake and a
// saturating counter of accepted error words.
module coder_prio #(
   parameter int unsigned N_IN   = 10,
   parameter int unsigned W_CODE = 4,
   parameter int unsigned MODE   = 0,
   parameter int unsigned W_ERR  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [N_IN-1:0]   i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [W_CODE-1:0] o_code,
   output logic              o_err,
   input  logic              i_clr_cnt,
   output logic [W_ERR-1:0]  o_err_cnt
);

   if ((64'd1 << W_CODE) <= 64'(N_IN)) begin : g_bad_width
      $error("coder_prio: 2**W_CODE must exceed N_IN");
   end
   if (MODE > 2) begin : g_bad_mode
      $error("coder_prio: MODE must be 0, 1 or 2");
   end

   logic              out_valid;
   logic [W_CODE-1:0] out_code;
   logic              out_err;
   logic [W_ERR-1:0]  err_cnt;
   logic [W_CODE-1:0] enc_code;
   logic              enc_err;
   logic              accept;
   int unsigned       ones;
   int unsigned       hit;

   always_comb begin
      enc_code = '0;
      enc_err  = 1'b1;
      ones     = 0;
      hit      = 0;
      if (MODE == 1) begin
         // Scan downward so the lowest set bit is the last one recorded.
         for (int k = int'(N_IN) - 1; k >= 0; k--) begin
            if (i_data[k]) begin
               ones = ones + 1;
               hit  = k;
            end
         end
      end else begin
         for (int k = 0; k < int'(N_IN); k++) begin
            if (i_data[k]) begin
               ones = ones + 1;
               hit  = k;
            end
         end
      end
      if ((MODE == 0) ? (ones == 1) : (ones != 0)) begin
         enc_code = W_CODE'(hit + 1);
         enc_err  = 1'b0;
      end
   end

   assign o_ready = !out_valid || i_ready;
   assign accept  = i_valid && o_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         out_valid <= 1'b0;
         out_code  <= '0;
         out_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_code  <= enc_code;
         out_err   <= enc_err;
      end else if (i_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         err_cnt <= '0;
      end else if (i_clr_cnt) begin
         err_cnt <= '0;
      end else if (accept && enc_err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + W_ERR'(1);
      end
   end

   assign o_valid   = out_valid;
   assign o_code    = out_code;
   assign o_err     = out_err;
   assign o_err_cnt = err_cnt;

endmodule

// File: tb/tb_coder_prio.sv
// Directed bench for coder_prio: four instances (MODE 0/1/2 and a 2-bit
// counter variant) share one stimulus stream.
module tb_coder_prio;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid;
   logic       rdy;
   logic       clr;
   logic [9:0] data;

   logic       rdy0, rdy1, rdy2, rdy3;
   logic       val0, val1, val2, val3;
   logic [3:0] code0, code1, code2, code3;
   logic       err0, err1, err2, err3;
   logic [7:0] cnt0, cnt1, cnt2;
   logic [1:0] cnt3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   coder_prio #(.MODE(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy0), .i_data(data),
      .o_valid(val0), .i_ready(rdy), .o_code(code0), .o_err(err0), .i_clr_cnt(clr),
      .o_err_cnt(cnt0));
   coder_prio #(.MODE(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy1), .i_data(data),
      .o_valid(val1), .i_ready(rdy), .o_code(code1), .o_err(err1), .i_clr_cnt(clr),
      .o_err_cnt(cnt1));
   coder_prio #(.MODE(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy2), .i_data(data),
      .o_valid(val2), .i_ready(rdy), .o_code(code2), .o_err(err2), .i_clr_cnt(clr),
      .o_err_cnt(cnt2));
   coder_prio #(.MODE(0), .W_ERR(2)) dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy3), .i_data(data),
      .o_valid(val3), .i_ready(rdy), .o_code(code3), .o_err(err3), .i_clr_cnt(clr),
      .o_err_cnt(cnt3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; valid = 1'b0; rdy = 1'b1; clr = 1'b0; data = '0;
      #2;
      chk("rst_valid", 32'(val0), 0);
      chk("rst_code", 32'(code0), 0);
      chk("rst_err", 32'(err0), 0);
      chk("rst_cnt", 32'(cnt0), 0);
      chk("rst_ready", 32'(rdy0), 1);
      tick();
      rst_n = 1'b1;
      chk("rel_ready", 32'(rdy0), 1);

      // One-hot stream, back to back
      valid = 1'b1; data = 10'b0000000001;
      tick();
      chk("oh1_valid", 32'(val0), 1);
      chk("oh1_code", 32'(code0), 1);
      chk("oh1_err", 32'(err0), 0);
      data = 10'b0000001000;
      tick();
      chk("oh4_valid", 32'(val0), 1);
      chk("oh4_code", 32'(code0), 4);
      data = 10'b1000000000;
      tick();
      chk("oh10_valid", 32'(val0), 1);
      chk("oh10_code", 32'(code0), 10);
      chk("oh10_err", 32'(err0), 0);

      // Two bits: error in MODE 0, priority in MODE 1/2
      data = 10'b0000000110;
      tick();
      chk("m0_two_code", 32'(code0), 0);
      chk("m0_two_err", 32'(err0), 1);
      chk("m1_two_code", 32'(code1), 2);
      chk("m1_two_err", 32'(err1), 0);
      chk("m2_two_code", 32'(code2), 3);
      data = 10'b0000000000;
      tick();
      chk("m0_zero_code", 32'(code0), 0);
      chk("m0_zero_err", 32'(err0), 1);
      chk("m0_cnt2", 32'(cnt0), 2);
      chk("m1_zero_err", 32'(err1), 1);
      chk("m2_zero_code", 32'(code2), 0);
      data = 10'b1000000001;
      tick();
      chk("m2_ends_code", 32'(code2), 10);
      chk("m2_ends_err", 32'(err2), 0);
      chk("m1_ends_code", 32'(code1), 1);
      chk("m0_ends_err", 32'(err0), 1);
      chk("m0_cnt3", 32'(cnt0), 3);

      // Backpressure: result held, i_data ignored
      data = 10'b0000010000;
      tick();
      chk("bp_code", 32'(code0), 5);
      rdy = 1'b0; data = 10'b1111111111;
      #1;
      chk("bp_ready_lo", 32'(rdy0), 0);
      tick();
      chk("bp1_code", 32'(code0), 5);
      chk("bp1_valid", 32'(val0), 1);
      data = 10'b0000000000;
      tick();
      chk("bp2_code", 32'(code0), 5);
      chk("bp2_err", 32'(err0), 0);
      data = 10'b0000000001;
      tick();
      chk("bp3_code", 32'(code0), 5);
      chk("bp3_ready", 32'(rdy0), 0);
      chk("bp_cnt_hold", 32'(cnt0), 3);
      rdy = 1'b1; data = 10'b0000000010;
      #1;
      chk("bp_ready_hi", 32'(rdy0), 1);
      tick();
      chk("bp_next_code", 32'(code0), 2);
      chk("bp_next_valid", 32'(val0), 1);
      valid = 1'b0;
      tick();
      chk("drain_valid", 32'(val0), 0);

      // Clear then saturate the 2-bit counter
      chk("w2_sat_pre", 32'(cnt3), 3);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_cnt0", 32'(cnt0), 0);
      chk("clr_cnt3", 32'(cnt3), 0);
      valid = 1'b1; data = 10'b0000000000;
      tick();
      chk("w2_cnt_a", 32'(cnt3), 1);
      tick();
      chk("w2_cnt_b", 32'(cnt3), 2);
      tick();
      chk("w2_cnt_c", 32'(cnt3), 3);
      tick();
      chk("w2_cnt_d", 32'(cnt3), 3);
      tick();
      chk("w2_cnt_e", 32'(cnt3), 3);
      chk("w8_cnt5", 32'(cnt0), 5);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("w2_clr_wins", 32'(cnt3), 0);
      chk("w8_clr_wins", 32'(cnt0), 0);

      // Asynchronous reset with a held result
      tick();
      tick();
      tick();
      chk("pre_rst_cnt", 32'(cnt3), 3);
      rdy = 1'b0; valid = 1'b0;
      tick();
      chk("pre_rst_valid", 32'(val0), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(val0), 0);
      chk("arst_code", 32'(code0), 0);
      chk("arst_err", 32'(err0), 0);
      chk("arst_cnt0", 32'(cnt0), 0);
      chk("arst_cnt3", 32'(cnt3), 0);
      chk("arst_ready", 32'(rdy0), 1);
      tick();
      rst_n = 1'b1; rdy = 1'b1; valid = 1'b1; data = 10'b0100000000;
      #1;
      chk("post_ready", 32'(rdy0), 1);
      tick();
      chk("post_code", 32'(code0), 9);
      chk("post_valid", 32'(val0), 1);
      chk("post_err", 32'(err0), 0);
      valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
